// File: rtl/ace_read_responder_if.sv
// ACE bundle between an initiator and ace_read_responder.
// Slave side drives AR-ready, R channel and all write/snoop tie-offs.
interface ace_if #(
  parameter int ACE_XDATA_WIDTH = 32,
  parameter int ACE_ID_WIDTH    = 4,
  parameter int ACE_ADDR_WIDTH  = 32
) ();
  logic                      arvalid;
  logic                      arready;
  logic [ACE_ID_WIDTH-1:0]   arid;
  logic [ACE_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;

  logic                       rvalid;
  logic                       rready;
  logic [ACE_ID_WIDTH-1:0]    rid;
  logic [ACE_XDATA_WIDTH-1:0] rdata;
  logic [3:0]                 rresp;
  logic                       rlast;
  logic                       rack;

  logic                      awvalid;
  logic                      awready;
  logic                      wvalid;
  logic                      wready;
  logic                      bvalid;
  logic                      bready;
  logic [ACE_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;

  logic                      acvalid;
  logic                      acready;
  logic [ACE_ADDR_WIDTH-1:0] acaddr;
  logic [3:0]                acsnoop;
  logic [2:0]                acprot;
  logic                      crvalid;
  logic                      crready;
  logic                      cdvalid;
  logic                      cdready;

  modport s (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    input  rready, rack,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    output awready, wready, bvalid, bid, bresp,
    output acvalid, acaddr, acsnoop, acprot,
    output crready, cdready
  );

  modport m (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    output rready, rack,
    output awvalid, wvalid, bready,
    output acready, crvalid, cdvalid,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    input  awready, wready, bvalid, bid, bresp,
    input  acvalid, acaddr, acsnoop, acprot,
    input  crready, cdready
  );
endinterface

// File: rtl/ace_read_responder.sv
// ACE read-path responder backed by a word memory (one txn in flight).
// Define ACE_READ_RESPONDER_STALL_EN for LFSR-driven bubble insertion.
module ace_read_responder #(
  parameter int              ACE_XDATA_WIDTH = 32,
  parameter int              ACE_ID_WIDTH    = 4,
  parameter int              ACE_ADDR_WIDTH  = 32,
  parameter int              MEM_DEPTH_WORDS = 1024,
  parameter longint unsigned BASE_ADDR       = 0,
  parameter int              READ_LATENCY    = 1,
  parameter string           MEM_INIT_FILE   = ""
) (
  input logic clk,
  input logic rst,
  ace_if.s    ace_sif
);

  localparam int DW  = ACE_XDATA_WIDTH;
  localparam int IDW = ACE_ID_WIDTH;
  localparam int AW  = ACE_ADDR_WIDTH;
  localparam int LB  = $clog2(DW / 8);
  localparam int IW  = $clog2(MEM_DEPTH_WORDS);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
    $error("ace_read_responder: READ_LATENCY must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    BURST,
    ACKWAIT
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] mem [MEM_DEPTH_WORDS];

  logic [IDW-1:0] id_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     len_q;
  logic [7:0]     beat_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [3:0]     dly_q;

  logic           rvalid_q;
  logic           pend_q;
  logic           rlast_q;
  logic [IDW-1:0] rid_q;
  logic [DW-1:0]  rdata_q;
  logic [1:0]     rerr_q;

  logic stall_beat;
  logic stall_ar;
  logic arready_w;
  logic ar_hs;
  logic r_hs;

  logic           present;
  logic [AW-1:0]  ld_addr;
  logic [IDW-1:0] ld_id;
  logic [7:0]     ld_len;
  logic [2:0]     ld_size;
  logic [1:0]     ld_burst;
  logic [7:0]     ld_beat;
  logic           ld_last;
  logic [AW-1:0]  ld_off;
  logic [IW-1:0]  ld_idx;
  logic           ld_bad;

  logic [AW-1:0] step;
  logic [AW-1:0] wmask;
  logic [AW-1:0] addr_nxt;

`ifdef ACE_READ_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR, taps 16/14/13/11.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0],
                 lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall_beat = (lfsr_q[1:0] == 2'b00);
  assign stall_ar   = (lfsr_q[3:2] == 2'b00);
`else
  assign stall_beat = 1'b0;
  assign stall_ar   = 1'b0;
`endif

  assign arready_w = (state_q == IDLE) && !stall_ar;
  assign ar_hs     = arready_w && ace_sif.arvalid;
  assign r_hs      = rvalid_q && ace_sif.rready;

  // Next beat address for FIXED / INCR / WRAP bursts.
  always_comb begin
    step  = AW'(1) << size_q;
    wmask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    unique case (burst_q)
      2'd0:    addr_nxt = addr_q;
      2'd2:    addr_nxt = (addr_q & ~wmask) | ((addr_q + step) & wmask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  // Next state and selection of the beat to present.
  always_comb begin
    state_d  = state_q;
    present  = 1'b0;
    ld_addr  = addr_nxt;
    ld_id    = id_q;
    ld_len   = len_q;
    ld_size  = size_q;
    ld_burst = burst_q;
    ld_beat  = 8'(beat_q + 8'd1);
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d  = (READ_LATENCY == 1) ? BURST : DELAY;
          present  = (READ_LATENCY == 1);
          ld_addr  = ace_sif.araddr;
          ld_id    = ace_sif.arid;
          ld_len   = ace_sif.arlen;
          ld_size  = ace_sif.arsize;
          ld_burst = ace_sif.arburst;
          ld_beat  = 8'd0;
        end
      end
      DELAY: begin
        if (dly_q == 4'd1) begin
          state_d = BURST;
          present = 1'b1;
          ld_addr = addr_q;
          ld_beat = 8'd0;
        end
      end
      BURST: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d = ace_sif.rack ? IDLE : ACKWAIT;
          end else begin
            present = 1'b1;
          end
        end
      end
      ACKWAIT: begin
        if (ace_sif.rack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-beat word index and SLVERR decode.
  always_comb begin
    ld_last = (ld_beat == ld_len);
    ld_off  = ld_addr - BASE;
    ld_idx  = ld_off[LB +: IW];
    ld_bad  = (ld_addr < BASE)
           || ((ld_off >> LB) >= AW'(MEM_DEPTH_WORDS))
           || (ld_burst == 2'd3)
           || (ld_size > 3'(LB));
    if (ld_burst == 2'd2) begin
      if (!(ld_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
        ld_bad = 1'b1;
      end
      if ((ld_addr & ((AW'(1) << ld_size) - AW'(1))) != '0) begin
        ld_bad = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, latency countdown and burst address walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      dly_q   <= '0;
    end else begin
      if (ar_hs) begin
        id_q    <= ace_sif.arid;
        addr_q  <= ace_sif.araddr;
        len_q   <= ace_sif.arlen;
        size_q  <= ace_sif.arsize;
        burst_q <= ace_sif.arburst;
        beat_q  <= 8'd0;
        dly_q   <= 4'(READ_LATENCY - 1);
      end else if (state_q == DELAY) begin
        dly_q <= dly_q - 4'd1;
      end
      if (present && state_q == BURST) begin
        addr_q <= addr_nxt;
        beat_q <= ld_beat;
      end
    end
  end

  // Registered R channel; synchronous memory read feeds rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      pend_q   <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rerr_q   <= 2'b00;
    end else if (present) begin
      rvalid_q <= !stall_beat;
      pend_q   <= stall_beat;
      rid_q    <= ld_id;
      rlast_q  <= ld_last;
      rerr_q   <= ld_bad ? 2'b10 : 2'b00;
      rdata_q  <= ld_bad ? '0 : mem[ld_idx];
    end else if (pend_q && !stall_beat) begin
      rvalid_q <= 1'b1;
      pend_q   <= 1'b0;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

  assign ace_sif.arready = arready_w;
  assign ace_sif.rvalid  = rvalid_q;
  assign ace_sif.rid     = rid_q;
  assign ace_sif.rdata   = rdata_q;
  assign ace_sif.rresp   = {2'b00, rerr_q};
  assign ace_sif.rlast   = rlast_q;

  assign ace_sif.awready = 1'b0;
  assign ace_sif.wready  = 1'b0;
  assign ace_sif.bvalid  = 1'b0;
  assign ace_sif.bid     = '0;
  assign ace_sif.bresp   = 2'b00;
  assign ace_sif.acvalid = 1'b0;
  assign ace_sif.acaddr  = '0;
  assign ace_sif.acsnoop = 4'd0;
  assign ace_sif.acprot  = 3'd0;
  assign ace_sif.crready = 1'b1;
  assign ace_sif.cdready = 1'b1;

endmodule

// File: tb/tb_ace_read_responder.sv
// Bench for ace_read_responder: directed cases then random bursts,
// every beat checked against an address-arithmetic reference model.
module tb_ace_read_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ace_if #(
    .ACE_XDATA_WIDTH(32),
    .ACE_ID_WIDTH(4),
    .ACE_ADDR_WIDTH(32)
  ) bus ();

  ace_read_responder #(
    .ACE_XDATA_WIDTH(32),
    .ACE_ID_WIDTH(4),
    .ACE_ADDR_WIDTH(32),
    .MEM_DEPTH_WORDS(DEPTH),
    .BASE_ADDR(0),
    .READ_LATENCY(1),
    .MEM_INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .ace_sif(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: beat i of a burst, from plain address arithmetic.
  function automatic void exp_beat(input logic [31:0] a, input int len,
                                   input int size, input int burst,
                                   input int i, output logic [31:0] d,
                                   output logic [3:0] resp);
    longint unsigned bytes, w, base, ad;
    bit bad;
    bytes = 64'd1 << size;
    case (burst)
      0: ad = a;
      2: begin
        w    = longint'(len + 1) * bytes;
        base = (a / w) * w;
        ad   = base + ((a - base) + longint'(i) * bytes) % w;
      end
      default: ad = a + longint'(i) * bytes;
    endcase
    bad = (ad / 4 >= DEPTH) || (burst == 3) || (bytes > 4);
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
      bad = 1;
    if (burst == 2 && (ad % bytes) != 0)
      bad = 1;
    d    = bad ? 32'h0 : 32'h1000_0000 + 32'(ad / 4);
    resp = bad ? 4'b0010 : 4'b0000;
  endfunction

  // rmode: 0 always ready, 1 toggling from 1, 2 random (with early rack)
  task automatic do_read(input logic [3:0] id, input logic [31:0] a,
                         input int len, input int size, input int burst,
                         input int rmode, input int ackdly,
                         input string tag);
    int beat, cyc, wt;
    logic [31:0] ed, hd;
    logic [3:0] er;
    logic held, hl, rr;
    bus.arid    = id;
    bus.araddr  = a;
    bus.arlen   = 8'(len);
    bus.arsize  = 3'(size);
    bus.arburst = 2'(burst);
    bus.arvalid = 1'b1;
    wt = 0;
    while (bus.arready !== 1'b1 && wt < 50) begin
      @(posedge clk); #1; wt++;
    end
    chk({tag, "_ar_accept"}, 64'(wt < 50), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk({tag, "_latency"}, 64'(bus.rvalid), 64'd1);
    chk({tag, "_ar_busy"}, 64'(bus.arready), 64'd0);
    beat = 0;
    cyc  = 0;
    held = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    while (beat <= len && cyc < 400) begin
      if (rmode == 0) rr = 1'b1;
      else if (rmode == 1) rr = ~cyc[0];
      else rr = 1'($urandom_range(0, 1));
      bus.rready = rr;
      if (rr && bus.rvalid && beat == len)
        bus.rack = (ackdly == 0);
      else
        bus.rack = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.rvalid) begin
        if (held) begin
          chk({tag, "_hold"}, {31'd0, bus.rlast, bus.rdata},
              {31'd0, hl, hd});
        end
        if (rr) begin
          exp_beat(a, len, size, burst, beat, ed, er);
          chk($sformatf("%s_data%0d", tag, beat), 64'(bus.rdata), 64'(ed));
          chk($sformatf("%s_resp%0d", tag, beat), 64'(bus.rresp), 64'(er));
          chk($sformatf("%s_last%0d", tag, beat), 64'(bus.rlast),
              64'(beat == len));
          chk($sformatf("%s_id%0d", tag, beat), 64'(bus.rid), 64'(id));
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = bus.rdata;
          hl   = bus.rlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_beats"}, 64'(beat), 64'(len + 1));
    bus.rready = 1'b0;
    bus.rack   = 1'b0;
    if (ackdly > 0) begin
      bus.arid    = 4'hF;
      bus.araddr  = 32'h0;
      bus.arlen   = 8'd0;
      bus.arsize  = 3'd2;
      bus.arburst = 2'd1;
      bus.arvalid = 1'b1;
      for (int d = 0; d < ackdly; d++) begin
        chk($sformatf("%s_ackwait_ar%0d", tag, d), 64'(bus.arready), 64'd0);
        chk($sformatf("%s_ackwait_rv%0d", tag, d), 64'(bus.rvalid), 64'd0);
        @(posedge clk); #1;
      end
      bus.rack = 1'b1;
      @(posedge clk); #1;
      bus.rack    = 1'b0;
      chk({tag, "_no_early_accept"}, 64'(bus.rvalid), 64'd0);
      bus.arvalid = 1'b0;
    end
    chk({tag, "_idle_again"}, 64'(bus.arready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int len, size, burst, rmode, ackdly;
    logic [31:0] a;
    rst         = 1'b1;
    bus.arvalid = 1'b0;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.arlen   = '0;
    bus.arsize  = '0;
    bus.arburst = '0;
    bus.rready  = 1'b0;
    bus.rack    = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.acready = 1'b0;
    bus.crvalid = 1'b0;
    bus.cdvalid = 1'b0;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = 32'h1000_0000 + 32'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rlast", 64'(bus.rlast), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_rresp", 64'(bus.rresp), 64'd0);
    chk("rst_rid", 64'(bus.rid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_arready", 64'(bus.arready), 64'd1);
    chk("tie_aw_w_b", {61'd0, bus.awready, bus.wready, bus.bvalid}, 64'd0);
    chk("tie_ac", 64'(bus.acvalid), 64'd0);
    chk("tie_cr_cd", {62'd0, bus.crready, bus.cdready}, 64'd3);

    do_read(4'd1, 32'h8, 0, 2, 1, 0, 0, "single");
    do_read(4'd2, 32'h10, 3, 2, 1, 1, 0, "incr_bp");
    do_read(4'd3, 32'h18, 3, 2, 2, 0, 0, "wrap");
    do_read(4'd4, 32'(DEPTH * 4), 0, 2, 1, 0, 0, "err_oob");
    do_read(4'd5, 32'h20, 1, 2, 3, 0, 0, "err_burst3");
    do_read(4'd6, 32'h40, 0, 2, 1, 0, 5, "rack_wait");

    bus.arid    = 4'd7;
    bus.araddr  = 32'h0;
    bus.arlen   = 8'd7;
    bus.arsize  = 3'd2;
    bus.arburst = 2'd1;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    @(posedge clk); #1;
    chk("midrst_beat1_valid", 64'(bus.rvalid), 64'd1);
    chk("midrst_beat1_data", 64'(bus.rdata), 64'h1000_0001);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rvalid_drop", 64'(bus.rvalid), 64'd0);
    rst        = 1'b0;
    bus.rready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_arready", 64'(bus.arready), 64'd1);
    chk("midrst_quiet", 64'(bus.rvalid), 64'd0);
    do_read(4'd8, 32'h0, 0, 2, 1, 0, 0, "post_rst");

    for (int t = 0; t < 40; t++) begin
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = 1;
        2: len = 3;
        3: len = 7;
        4: len = 15;
        default: len = $urandom_range(0, 15);
      endcase
      a = 32'($urandom_range(0, DEPTH * 4 + 64));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 32'd1);
      rmode  = $urandom_range(0, 2);
      ackdly = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      do_read(4'($urandom_range(0, 15)), a, len, size, burst, rmode,
              ackdly, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
